// File: rtl/nf_ahb_arb_pkg.sv
// Shared types and helpers for the AHB core-port request arbiter.
package nf_ahb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_st_t;

  localparam logic [31:0] ARB_RD_ERR = 32'h0;

  // Index base+off wrapped into 0..n-1; base < n and off < n always hold here.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/nf_rr_pick.sv
// Round-robin picker: first pending requester at or above the rr pointer, wrapping.
module nf_rr_pick
  import nf_ahb_arb_pkg::*;
#(
  parameter int REQ_C = 2,
  localparam int IDX_W = $clog2(REQ_C)
) (
  input  logic [REQ_C-1:0] pend_i,
  input  logic [IDX_W-1:0] rr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest pending slot is written last.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    for (int k = REQ_C - 1; k >= 0; k--) begin
      idx = IDX_W'(rr_wrap(int'(rr_i), k, REQ_C));
      if (pend_i[idx]) grant_o = idx;
    end
  end

  assign any_o = |pend_i;

endmodule

// File: rtl/nf_ahb_req_arb.sv
// Shares the single nf_ahb_top core port between REQ_C requesters: one buffered
// request per requester, round-robin grant, one transaction at a time, timeout recovery.
//
// state     | meaning
// ARB_IDLE  | nothing in flight; grant the next pending requester
// ARB_ISSUE | req_dm pulse with the granted requester's fields
// ARB_WAIT  | fields held, waiting for req_ack_dm or timeout
module nf_ahb_req_arb
  import nf_ahb_arb_pkg::*;
#(
  parameter int REQ_C = 2,
  parameter int TMO_C = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [REQ_C-1:0]       req_i,
  input  logic [REQ_C-1:0]       we_i,
  input  logic [REQ_C-1:0][31:0] addr_i,
  input  logic [REQ_C-1:0][31:0] wd_i,
  output logic [REQ_C-1:0]       busy_o,
  output logic [REQ_C-1:0]       ack_o,
  output logic [REQ_C-1:0]       err_o,
  output logic [REQ_C-1:0][31:0] rd_o,
  output logic [31:0]            addr_dm,
  output logic [31:0]            wd_dm,
  output logic                   we_dm,
  output logic                   req_dm,
  input  logic [31:0]            rd_dm,
  input  logic                   req_ack_dm
);

  localparam int IDX_W = $clog2(REQ_C);
  localparam int CNT_W = $clog2(TMO_C + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_C - 1);

  arb_st_t                 state_q, state_d;
  logic [REQ_C-1:0]        pend_q, pend_d;
  logic [REQ_C-1:0]        we_buf_q, we_buf_d;
  logic [REQ_C-1:0][31:0]  addr_buf_q, addr_buf_d;
  logic [REQ_C-1:0][31:0]  wd_buf_q, wd_buf_d;
  logic [IDX_W-1:0]        g_q, g_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REQ_C-1:0]        ack_q, ack_d;
  logic [REQ_C-1:0]        err_q, err_d;
  logic [REQ_C-1:0][31:0]  rd_q, rd_d;
  logic [31:0]             addr_dm_q, addr_dm_d;
  logic [31:0]             wd_dm_q, wd_dm_d;
  logic                    we_dm_q, we_dm_d;
  logic                    req_dm_q, req_dm_d;

  logic [IDX_W-1:0]        grant;
  logic                    any_pend;
  logic                    done;
  logic                    tmo;
  logic [REQ_C-1:0]        clr;

  nf_rr_pick #(.REQ_C(REQ_C)) u_pick (
    .pend_i  (pend_q),
    .rr_i    (rr_q),
    .grant_o (grant),
    .any_o   (any_pend)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    we_buf_d   = we_buf_q;
    addr_buf_d = addr_buf_q;
    wd_buf_d   = wd_buf_q;
    g_d        = g_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    err_d      = '0;
    rd_d       = rd_q;
    addr_dm_d  = addr_dm_q;
    wd_dm_d    = wd_dm_q;
    we_dm_d    = we_dm_q;
    req_dm_d   = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    clr        = '0;

    case (state_q)
      ARB_IDLE: begin
        if (any_pend) begin
          g_d       = grant;
          state_d   = ARB_ISSUE;
          req_dm_d  = 1'b1;
          addr_dm_d = addr_buf_q[grant];
          wd_dm_d   = wd_buf_q[grant];
          we_dm_d   = we_buf_q[grant];
        end
      end
      ARB_ISSUE: begin
        cnt_d = '0;
        if (req_ack_dm) done = 1'b1;
        else            state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (req_ack_dm)            done = 1'b1;
        else if (cnt_q == CNT_LAST) tmo = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (done || tmo) begin
      clr[g_q]   = 1'b1;
      ack_d[g_q] = 1'b1;
      err_d[g_q] = tmo;
      rd_d[g_q]  = tmo ? ARB_RD_ERR : rd_dm;
      rr_d       = IDX_W'(rr_wrap(int'(g_q), 1, REQ_C));
      state_d    = ARB_IDLE;
    end

    // A slot completing this cycle is free again, so a new pulse on it is taken.
    for (int i = 0; i < REQ_C; i++) begin
      if (req_i[i] && (!pend_q[i] || clr[i])) begin
        pend_d[i]     = 1'b1;
        we_buf_d[i]   = we_i[i];
        addr_buf_d[i] = addr_i[i];
        wd_buf_d[i]   = wd_i[i];
      end else if (clr[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= ARB_IDLE;
      pend_q     <= '0;
      we_buf_q   <= '0;
      addr_buf_q <= '0;
      wd_buf_q   <= '0;
      g_q        <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rd_q       <= '0;
      addr_dm_q  <= '0;
      wd_dm_q    <= '0;
      we_dm_q    <= 1'b0;
      req_dm_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      we_buf_q   <= we_buf_d;
      addr_buf_q <= addr_buf_d;
      wd_buf_q   <= wd_buf_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      addr_dm_q  <= addr_dm_d;
      wd_dm_q    <= wd_dm_d;
      we_dm_q    <= we_dm_d;
      req_dm_q   <= req_dm_d;
    end
  end

  assign busy_o  = pend_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rd_o    = rd_q;
  assign addr_dm = addr_dm_q;
  assign wd_dm   = wd_dm_q;
  assign we_dm   = we_dm_q;
  assign req_dm  = req_dm_q;

endmodule

// File: tb/tb_nf_ahb_req_arb.sv
// Scoreboard bench for nf_ahb_req_arb with a behavioural memory slave on the core port.
module tb_nf_ahb_req_arb;

  localparam logic [31:0] WR_RD = 32'h1357_9bdf;

  logic             clk;
  logic             resetn;
  logic [1:0]       req_i, we_i;
  logic [1:0][31:0] addr_i, wd_i;
  logic [1:0]       busy_o, ack_o, err_o;
  logic [1:0][31:0] rd_o;
  logic [31:0]      addr_dm, wd_dm, rd_dm;
  logic             we_dm, req_dm, req_ack_dm;

  nf_ahb_req_arb #(.REQ_C(2), .TMO_C(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wd_i       (wd_i),
    .busy_o     (busy_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .rd_o       (rd_o),
    .addr_dm    (addr_dm),
    .wd_dm      (wd_dm),
    .we_dm      (we_dm),
    .req_dm     (req_dm),
    .rd_dm      (rd_dm),
    .req_ack_dm (req_ack_dm)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wd; } dm_t;
  typedef struct { int idx; logic err; logic [31:0] rd; } ack_t;

  dm_t  exp_dm[$];
  ack_t exp_ack[$];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int drive_cyc = 0;
  int last_req_cyc = 0;
  int prev_req_cyc = 0;
  int last_ack_cyc = 0;
  int ack_cnt = 0;

  int   slv_mode = 0;
  int   slv_lat = 1;
  logic stray_tog = 1'b0;
  logic [31:0] mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memory slave: acks slv_lat cycles after the req_dm cycle; mode 1 never acks
  initial begin : slave
    logic        s_req, s_we, p_we, p_pend, stray_seen;
    logic [31:0] s_addr, s_wd, p_addr, p_wd;
    int          p_wait;
    p_pend = 1'b0; p_wait = 0; p_we = 1'b0; p_addr = '0; p_wd = '0; stray_seen = 1'b0;
    req_ack_dm = 1'b0;
    rd_dm = '0;
    forever begin
      @(posedge clk);
      s_req = req_dm; s_we = we_dm; s_addr = addr_dm; s_wd = wd_dm;
      #1;
      req_ack_dm = 1'b0;
      if (resetn) begin
        p_pend = 1'b0;
      end else begin
        if (s_req && slv_mode == 0) begin
          p_pend = 1'b1; p_wait = slv_lat - 1; p_we = s_we; p_addr = s_addr; p_wd = s_wd;
        end
        if (stray_tog != stray_seen) begin
          stray_seen = stray_tog;
          req_ack_dm = 1'b1;
          rd_dm = 32'hdead_beef;
        end else if (p_pend) begin
          if (p_wait == 0) begin
            req_ack_dm = 1'b1;
            if (p_we) begin
              mem[p_addr] = p_wd;
              rd_dm = WR_RD;
            end else begin
              rd_dm = mem.exists(p_addr) ? mem[p_addr] : 32'h0;
            end
            p_pend = 1'b0;
          end else begin
            p_wait--;
          end
        end
      end
    end
  end

  task automatic monitor();
    dm_t  d;
    ack_t a;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        if (req_dm === 1'b1) begin
          prev_req_cyc = last_req_cyc;
          last_req_cyc = cyc;
          tests_run++;
          if (exp_dm.size() == 0) begin
            tests_failed++;
            $display("FAIL dm_unexpected: req_dm=1 addr_dm=%h wd_dm=%h, required no transaction", addr_dm, wd_dm);
          end else begin
            d = exp_dm.pop_front();
            if (we_dm !== d.we || addr_dm !== d.addr || wd_dm !== d.wd) begin
              tests_failed++;
              $display("FAIL dm_fields: got we=%b addr=%h wd=%h, required we=%b addr=%h wd=%h",
                       we_dm, addr_dm, wd_dm, d.we, d.addr, d.wd);
            end
          end
        end
        if ((err_o & ~ack_o) !== 2'b00) begin
          tests_run++;
          tests_failed++;
          $display("FAIL err_without_ack: err_o=%b ack_o=%b, required err only with ack", err_o, ack_o);
        end
        for (int i = 0; i < 2; i++) begin
          if (ack_o[i] === 1'b1) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            tests_run++;
            if (exp_ack.size() == 0) begin
              tests_failed++;
              $display("FAIL ack_unexpected: ack_o[%0d]=1 rd_o=%h, required no ack", i, rd_o[i]);
            end else begin
              a = exp_ack.pop_front();
              if (a.idx != i || err_o[i] !== a.err || rd_o[i] !== a.rd) begin
                tests_failed++;
                $display("FAIL ack_result: got idx=%0d err=%b rd=%h, required idx=%0d err=%b rd=%h",
                         i, err_o[i], rd_o[i], a.idx, a.err, a.rd);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic push_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    dm_t t;
    t.we = we; t.addr = a; t.wd = d;
    exp_dm.push_back(t);
  endtask

  task automatic push_ack(input int idx, input logic err, input logic [31:0] rd);
    ack_t t;
    t.idx = idx; t.err = err; t.rd = rd;
    exp_ack.push_back(t);
  endtask

  task automatic set_fields(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    we_i[i] = we;
    addr_i[i] = a;
    wd_i[i] = d;
  endtask

  task automatic pulse(input logic [1:0] m);
    req_i = m;
    drive_cyc = cyc;
    @(posedge clk); #1;
    req_i = 2'b00;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_dm.size() == 0 && exp_ack.size() == 0 && busy_o == 2'b00)) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (exp_dm.size() != 0 || exp_ack.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d dm and %0d ack outstanding after %0d cycles, required 0",
               exp_dm.size(), exp_ack.size(), budget);
      exp_dm.delete();
      exp_ack.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1; resetn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run += 4;
    if ({busy_o, ack_o, err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%b ack=%b err=%b, required all 0", busy_o, ack_o, err_o);
    end
    if (rd_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_rd: rd_o=%h, required 0", rd_o);
    end
    if (req_dm !== 1'b0 || we_dm !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dm_ctl: req_dm=%b we_dm=%b, required 0", req_dm, we_dm);
    end
    if (addr_dm !== 32'h0 || wd_dm !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_dm_data: addr_dm=%h wd_dm=%h, required 0", addr_dm, wd_dm);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_single_write();
    set_fields(1, 1'b1, 32'h0000_0004, 32'h0000_005a);
    push_dm(1'b1, 32'h0000_0004, 32'h0000_005a);
    push_ack(1, 1'b0, WR_RD);
    pulse(2'b10);
    wait_drain(30);
    tests_run += 3;
    if (last_req_cyc - drive_cyc != 2) begin
      tests_failed++;
      $display("FAIL write_latency: req_dm %0d cycles after req_i, required 2", last_req_cyc - drive_cyc);
    end
    if (mem[32'h0000_0004] !== 32'h0000_005a) begin
      tests_failed++;
      $display("FAIL write_gpo: slave holds %h, required 0000005a", mem[32'h0000_0004]);
    end
    if (rd_o[1] !== WR_RD) begin
      tests_failed++;
      $display("FAIL write_rd_hold: rd_o[1]=%h, required %h", rd_o[1], WR_RD);
    end
  endtask

  task automatic test_read();
    set_fields(0, 1'b0, 32'h0000_0004, 32'h0);
    push_dm(1'b0, 32'h0000_0004, 32'h0);
    push_ack(0, 1'b0, 32'h0000_005a);
    pulse(2'b01);
    wait_drain(30);
    tests_run++;
    if (busy_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_busy: busy_o[0]=%b after ack, required 0", busy_o[0]);
    end
  endtask

  task automatic test_rr();
    do_reset();
    set_fields(0, 1'b1, 32'h0002_0000, 32'h11);
    set_fields(1, 1'b1, 32'h0002_0004, 32'h22);
    push_dm(1'b1, 32'h0002_0000, 32'h11);
    push_dm(1'b1, 32'h0002_0004, 32'h22);
    push_ack(0, 1'b0, WR_RD);
    push_ack(1, 1'b0, WR_RD);
    pulse(2'b11);
    wait_drain(40);
    tests_run++;
    if (last_req_cyc - prev_req_cyc != 3) begin
      tests_failed++;
      $display("FAIL back_to_back_gap: req_dm spacing %0d cycles, required 3", last_req_cyc - prev_req_cyc);
    end
    // one more grant to requester 0 leaves the pointer on requester 1
    set_fields(0, 1'b0, 32'h0002_0000, 32'h0);
    push_dm(1'b0, 32'h0002_0000, 32'h0);
    push_ack(0, 1'b0, 32'h11);
    pulse(2'b01);
    wait_drain(30);
    set_fields(0, 1'b0, 32'h0002_0004, 32'h0);
    set_fields(1, 1'b0, 32'h0002_0000, 32'h0);
    push_dm(1'b0, 32'h0002_0000, 32'h0);
    push_dm(1'b0, 32'h0002_0004, 32'h0);
    push_ack(1, 1'b0, 32'h11);
    push_ack(0, 1'b0, 32'h22);
    pulse(2'b11);
    wait_drain(40);
  endtask

  task automatic test_timeout();
    int acks_before;
    slv_mode = 1;
    set_fields(0, 1'b0, 32'h0000_0030, 32'h0);
    push_dm(1'b0, 32'h0000_0030, 32'h0);
    push_ack(0, 1'b1, 32'h0);
    pulse(2'b01);
    wait_drain(40);
    tests_run += 2;
    if (last_ack_cyc - last_req_cyc != 9) begin
      tests_failed++;
      $display("FAIL timeout_latency: ack %0d cycles after issue, required 9", last_ack_cyc - last_req_cyc);
    end
    if (rd_o[0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_rd: rd_o[0]=%h, required 0", rd_o[0]);
    end
    slv_mode = 0;
    acks_before = ack_cnt;
    stray_tog = ~stray_tog;
    repeat (5) begin @(posedge clk); #1; end
    tests_run++;
    if (ack_cnt != acks_before) begin
      tests_failed++;
      $display("FAIL stray_ack: %0d acks after stray req_ack_dm, required 0", ack_cnt - acks_before);
    end
  endtask

  task automatic test_drop_and_ack_cycle();
    int  n;
    bit  hit;
    slv_lat = 4;
    set_fields(0, 1'b1, 32'h0000_0008, 32'h77);
    push_dm(1'b1, 32'h0000_0008, 32'h77);
    push_ack(0, 1'b0, WR_RD);
    pulse(2'b01);
    tests_run++;
    if (busy_o[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_set: busy_o[0]=%b after capture, required 1", busy_o[0]);
    end
    set_fields(0, 1'b1, 32'h0000_9999, 32'hbad);
    pulse(2'b01);
    hit = 1'b0;
    n = 0;
    while (n < 20 && !hit) begin
      @(posedge clk); #2;
      if (req_ack_dm === 1'b1) hit = 1'b1;
      n++;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL ack_cycle_wait: req_ack_dm not seen in %0d cycles, required within 20", n);
    end else begin
      set_fields(0, 1'b0, 32'h0000_0008, 32'h0);
      push_dm(1'b0, 32'h0000_0008, 32'h0);
      push_ack(0, 1'b0, 32'h77);
      req_i = 2'b01;
      @(posedge clk); #1;
      req_i = 2'b00;
    end
    wait_drain(40);
    slv_lat = 1;
  endtask

  task automatic test_reset_mid();
    slv_mode = 1;
    set_fields(1, 1'b1, 32'h0000_0040, 32'h33);
    push_dm(1'b1, 32'h0000_0040, 32'h33);
    pulse(2'b10);
    set_fields(0, 1'b0, 32'h0000_0004, 32'h0);
    pulse(2'b01);
    repeat (3) begin @(posedge clk); #1; end
    resetn = 1'b1;
    @(negedge clk);
    tests_run += 3;
    if (req_dm !== 1'b0 || busy_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_reset_state: req_dm=%b busy_o=%b, required 0 and 00", req_dm, busy_o);
    end
    if (ack_o !== 2'b00 || err_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_reset_ack: ack_o=%b err_o=%b, required 00", ack_o, err_o);
    end
    if (rd_o !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_rd: rd_o=%h, required 0", rd_o);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    slv_mode = 0;
    repeat (15) begin @(posedge clk); #1; end
    set_fields(1, 1'b0, 32'h0000_0004, 32'h0);
    push_dm(1'b0, 32'h0000_0004, 32'h0);
    push_ack(1, 1'b0, 32'h0000_005a);
    pulse(2'b10);
    wait_drain(30);
  endtask

  initial begin
    req_i = 2'b00;
    we_i = 2'b00;
    addr_i = '0;
    wd_i = '0;
    resetn = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single_write();
    test_read();
    test_rr();
    test_timeout();
    test_drop_and_ack_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
